imm_gen_pipe: RTL and testbench

Registered, parametrised RISC-V immediate generator and format classifier for the decode stage.
- Accepts one 32-bit instruction per cycle over a valid/ready handshake.
- Extracts and sign-extends the immediate to XLEN, classifies the instruction format and flags unsupported opcodes.
- Presents results one cycle later through a skid buffer, so upstream fetch and downstream execute decouple without bubbles.

---
 rtl/imm_pkg.sv | 28 ++
 rtl/imm_extract.sv | 68 ++++++
 rtl/imm_gen_pipe.sv | 106 ++++++++++
 tb/tb_imm_gen_pipe.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// Shared types and opcode constants for the decode-stage immediate generator.
package imm_pkg;

    typedef enum logic [2:0] {
        FMT_I    = 3'd0,
        FMT_S    = 3'd1,
        FMT_B    = 3'd2,
        FMT_U    = 3'd3,
        FMT_J    = 3'd4,
        FMT_Z    = 3'd5,
        FMT_NONE = 3'd6
    } fmt_e;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] LOAD      = 7'b0000011;
    localparam logic [6:0] JALR      = 7'b1100111;
    localparam logic [6:0] FENCE     = 7'b0001111;
    localparam logic [6:0] STORE     = 7'b0100011;
    localparam logic [6:0] BRANCH    = 7'b1100011;
    localparam logic [6:0] LUI       = 7'b0110111;
    localparam logic [6:0] AUIPC     = 7'b0010111;
    localparam logic [6:0] JAL       = 7'b1101111;
    localparam logic [6:0] SYSTEM    = 7'b1110011;
    localparam logic [6:0] OP        = 7'b0110011;
    localparam logic [6:0] OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OP_32     = 7'b0111011;

endpackage

// File: rtl/imm_extract.sv
// Combinational immediate extraction, format classification and legality check.
module imm_extract
    import imm_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int EN_ZICSR = 1
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output fmt_e            fmt,
    output logic            illegal
);

    // Decode by opcode; anything unrecognised falls out as illegal with imm=0, fmt=NONE.
    always_comb begin
        imm     = '0;
        fmt     = FMT_NONE;
        illegal = 1'b0;
        if (instr[1:0] != 2'b11) begin
            illegal = 1'b1;
        end else begin
            case (instr[6:0])
                OP_IMM, LOAD, JALR, FENCE: begin
                    fmt = FMT_I;
                    imm = XLEN'($signed(instr[31:20]));
                end
                STORE: begin
                    fmt = FMT_S;
                    imm = XLEN'($signed({instr[31:25], instr[11:7]}));
                end
                BRANCH: begin
                    fmt = FMT_B;
                    imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
                end
                LUI, AUIPC: begin
                    fmt = FMT_U;
                    imm = XLEN'($signed({instr[31:12], 12'b0}));
                end
                JAL: begin
                    fmt = FMT_J;
                    imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
                end
                SYSTEM: begin
                    // Only the immediate CSR forms (funct3[2]=1) carry a zimm.
                    if ((EN_ZICSR != 0) && instr[14]) begin
                        fmt = FMT_Z;
                        imm = XLEN'(instr[19:15]);
                    end
                end
                OP: begin
                end
                OP_IMM_32: begin
                    if (XLEN == 64) begin
                        fmt = FMT_I;
                        imm = XLEN'($signed(instr[31:20]));
                    end else begin
                        illegal = 1'b1;
                    end
                end
                OP_32: begin
                    if (XLEN != 64) illegal = 1'b1;
                end
                default: illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator: imm_extract followed by a main/skid output buffer.
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int TAG_W    = 8,
    parameter int SKID     = 1,
    parameter int EN_ZICSR = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [31:0]      out_instr,
    output logic [TAG_W-1:0] out_tag
);

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("imm_gen_pipe: XLEN must be 32 or 64");
    end

    // Entry layout: {imm, fmt, illegal, instr, tag}
    localparam int EW = XLEN + 3 + 1 + 32 + TAG_W;

    logic [XLEN-1:0] ext_imm;
    fmt_e            ext_fmt;
    logic            ext_illegal;
    logic [EW-1:0]   new_entry;

    logic            main_valid_q, main_valid_d;
    logic [EW-1:0]   main_q, main_d;
    logic            skid_valid_q, skid_valid_d;
    logic [EW-1:0]   skid_q, skid_d;

    logic            in_fire;
    logic            out_fire;

    imm_extract #(
        .XLEN     (XLEN),
        .EN_ZICSR (EN_ZICSR)
    ) u_extract (
        .instr   (in_instr),
        .imm     (ext_imm),
        .fmt     (ext_fmt),
        .illegal (ext_illegal)
    );

    assign new_entry = {ext_imm, ext_fmt, ext_illegal, in_instr, in_tag};

    // With a skid entry, in_ready comes straight from a flop so it never depends on out_ready.
    assign in_ready = (SKID != 0) ? !skid_valid_q : (!main_valid_q || out_ready);
    assign in_fire  = in_valid && in_ready;
    assign out_fire = main_valid_q && out_ready;

    // Next-state for main/skid: drain first, then place the incoming entry.
    always_comb begin
        main_valid_d = main_valid_q;
        main_d       = main_q;
        skid_valid_d = skid_valid_q;
        skid_d       = skid_q;
        if (out_fire) begin
            if (skid_valid_q) begin
                main_d       = skid_q;
                skid_valid_d = 1'b0;
            end else begin
                main_valid_d = 1'b0;
            end
        end
        if (in_fire) begin
            // in_ready guarantees skid is empty whenever main drains and accepts together.
            if (!main_valid_q || out_fire) begin
                main_d       = new_entry;
                main_valid_d = 1'b1;
            end else begin
                skid_d       = new_entry;
                skid_valid_d = 1'b1;
            end
        end
    end

    // Buffer registers; reset discards everything and zeroes the visible outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_valid_q <= 1'b0;
            main_q       <= '0;
            skid_valid_q <= 1'b0;
            skid_q       <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_q       <= main_d;
            skid_valid_q <= skid_valid_d;
            skid_q       <= skid_d;
        end
    end

    assign out_valid = main_valid_q;
    assign {out_imm, out_fmt, out_illegal, out_instr, out_tag} = main_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench: XLEN=32 and XLEN=64 instances share one stimulus stream.
module tb_imm_gen_pipe;

    localparam int NV = 23;
    localparam logic [2:0] F_I = 3'd0, F_S = 3'd1, F_B = 3'd2, F_U = 3'd3,
                           F_J = 3'd4, F_Z = 3'd5, F_N = 3'd6;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] imm32;
        logic [2:0]  fmt32;
        logic        ill32;
        logic [63:0] imm64;
        logic [2:0]  fmt64;
        logic        ill64;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic [7:0]  tag;
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_instr = '0;
    logic [7:0]  in_tag = '0;
    logic        out_ready = 1'b1;

    logic        rdy32, val32, ill32;
    logic [31:0] imm32, ins32;
    logic [2:0]  fmt32;
    logic [7:0]  tag32;
    logic        rdy64, val64, ill64;
    logic [63:0] imm64;
    logic [31:0] ins64;
    logic [2:0]  fmt64;
    logic [7:0]  tag64;

    int errors = 0;
    int checks = 0;
    int n_out32 = 0;
    int n_out64 = 0;
    logic [7:0] tag_ctr = 8'd1;
    bit   done_flag;
    vec_t vecs [NV];
    vec_t cur;
    exp_t q32[$];
    exp_t q64[$];

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .TAG_W(8), .SKID(1), .EN_ZICSR(1)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy32),
        .in_instr(in_instr), .in_tag(in_tag), .out_valid(val32), .out_ready(out_ready),
        .out_imm(imm32), .out_fmt(fmt32), .out_illegal(ill32),
        .out_instr(ins32), .out_tag(tag32)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(8), .SKID(1), .EN_ZICSR(1)) dut64 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy64),
        .in_instr(in_instr), .in_tag(in_tag), .out_valid(val64), .out_ready(out_ready),
        .out_imm(imm64), .out_fmt(fmt64), .out_illegal(ill64),
        .out_instr(ins64), .out_tag(tag64)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] i, input logic [31:0] m32, input logic [2:0] f32,
                                input logic l32, input logic [63:0] m64, input logic [2:0] f64,
                                input logic l64);
        vec_t v;
        v.instr = i; v.imm32 = m32; v.fmt32 = f32; v.ill32 = l32;
        v.imm64 = m64; v.fmt64 = f64; v.ill64 = l64;
        return v;
    endfunction

    function automatic exp_t mkexp(input logic [31:0] i, input logic [7:0] t, input logic [63:0] m,
                                   input logic [2:0] f, input logic l);
        exp_t e;
        e.instr = i; e.tag = t; e.imm = m; e.fmt = f; e.ill = l;
        return e;
    endfunction

    // Scoreboard: compare the head entry every valid cycle (covers hold-while-stalled), pop on transfer.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (val32) begin
                if (q32.size() == 0) chk("out32_valid_with_empty_sb", 64'(val32), 64'(0));
                else begin
                    e = q32[0];
                    chk("imm32", 64'(imm32), e.imm);
                    chk("fmt32", 64'(fmt32), 64'(e.fmt));
                    chk("ill32", 64'(ill32), 64'(e.ill));
                    chk("instr32", 64'(ins32), 64'(e.instr));
                    chk("tag32", 64'(tag32), 64'(e.tag));
                    if (out_ready) begin void'(q32.pop_front()); n_out32++; end
                end
            end
            if (val64) begin
                if (q64.size() == 0) chk("out64_valid_with_empty_sb", 64'(val64), 64'(0));
                else begin
                    e = q64[0];
                    chk("imm64", imm64, e.imm);
                    chk("fmt64", 64'(fmt64), 64'(e.fmt));
                    chk("ill64", 64'(ill64), 64'(e.ill));
                    chk("instr64", 64'(ins64), 64'(e.instr));
                    chk("tag64", 64'(tag64), 64'(e.tag));
                    if (out_ready) begin void'(q64.pop_front()); n_out64++; end
                end
            end
            if (in_valid && rdy32) q32.push_back(mkexp(cur.instr, in_tag, {32'b0, cur.imm32}, cur.fmt32, cur.ill32));
            if (in_valid && rdy64) q64.push_back(mkexp(cur.instr, in_tag, cur.imm64, cur.fmt64, cur.ill64));
        end
    end

    task automatic present(input int vi);
        cur      = vecs[vi];
        in_instr = vecs[vi].instr;
        in_tag   = tag_ctr;
        in_valid = 1'b1;
    endtask

    // Drive one vector until accepted; returns 1 time unit after the accepting edge.
    task automatic send(input int vi);
        int  budget;
        bit  acc;
        present(vi);
        budget = 0;
        acc    = 1'b0;
        while (!acc && budget < 50) begin
            @(negedge clk);
            acc = rdy32;
            @(posedge clk);
            #1;
            budget++;
        end
        if (!acc) chk("send_timeout", 64'(rdy32), 64'(1));
        in_valid = 1'b0;
        tag_ctr++;
    endtask

    task automatic drain();
        int b;
        out_ready = 1'b1;
        b = 0;
        while ((q32.size() != 0 || q64.size() != 0) && b < 50) begin
            @(posedge clk);
            #1;
            b++;
        end
        chk("drain_q32_empty", 64'(q32.size()), 64'(0));
        chk("drain_q64_empty", 64'(q64.size()), 64'(0));
    endtask

    initial begin
        int base32;

        vecs[0]  = mk(32'hFFF00093, 32'hFFFFFFFF, F_I, 0, 64'hFFFFFFFF_FFFFFFFF, F_I, 0);
        vecs[1]  = mk(32'hFE112E23, 32'hFFFFFFFC, F_S, 0, 64'hFFFFFFFF_FFFFFFFC, F_S, 0);
        vecs[2]  = mk(32'hFF9FF06F, 32'hFFFFFFF8, F_J, 0, 64'hFFFFFFFF_FFFFFFF8, F_J, 0);
        vecs[3]  = mk(32'h3002D073, 32'h00000005, F_Z, 0, 64'h5, F_Z, 0);
        vecs[4]  = mk(32'h800000B7, 32'h80000000, F_U, 0, 64'hFFFFFFFF_80000000, F_U, 0);
        vecs[5]  = mk(32'h0010009B, 32'h0, F_N, 1, 64'h1, F_I, 0);
        vecs[6]  = mk(32'h00000000, 32'h0, F_N, 1, 64'h0, F_N, 1);
        vecs[7]  = mk(32'hFE000EE3, 32'hFFFFFFFC, F_B, 0, 64'hFFFFFFFF_FFFFFFFC, F_B, 0);
        vecs[8]  = mk(32'h00000463, 32'h00000008, F_B, 0, 64'h8, F_B, 0);
        vecs[9]  = mk(32'h002081B3, 32'h0, F_N, 0, 64'h0, F_N, 0);
        vecs[10] = mk(32'h002081BB, 32'h0, F_N, 1, 64'h0, F_N, 0);
        vecs[11] = mk(32'h00000073, 32'h0, F_N, 0, 64'h0, F_N, 0);
        vecs[12] = mk(32'h7FF0A083, 32'h000007FF, F_I, 0, 64'h7FF, F_I, 0);
        vecs[13] = mk(32'h12345297, 32'h12345000, F_U, 0, 64'h12345000, F_U, 0);
        vecs[14] = mk(32'h001000EF, 32'h00000800, F_J, 0, 64'h800, F_J, 0);
        vecs[15] = mk(32'hFFF00091, 32'h0, F_N, 1, 64'h0, F_N, 1);
        vecs[16] = mk(32'h0000007F, 32'h0, F_N, 1, 64'h0, F_N, 1);
        vecs[17] = mk(32'h0FF0000F, 32'h000000FF, F_I, 0, 64'hFF, F_I, 0);
        vecs[18] = mk(32'h000080E7, 32'h0, F_I, 0, 64'h0, F_I, 0);
        vecs[19] = mk(32'h80000063, 32'hFFFFF000, F_B, 0, 64'hFFFFFFFF_FFFFF000, F_B, 0);
        vecs[20] = mk(32'h00112423, 32'h00000008, F_S, 0, 64'h8, F_S, 0);
        vecs[21] = mk(32'h300022F3, 32'h0, F_N, 0, 64'h0, F_N, 0);
        vecs[22] = mk(32'h340FF073, 32'h0000001F, F_Z, 0, 64'h1F, F_Z, 0);
        cur = vecs[0];

        // Reset values while rst is held high
        #2;
        chk("rst_valid32", 64'(val32), 64'(0));
        chk("rst_ready32", 64'(rdy32), 64'(1));
        chk("rst_imm32", 64'(imm32), 64'(0));
        chk("rst_fmt32", 64'(fmt32), 64'(0));
        chk("rst_ill32", 64'(ill32), 64'(0));
        chk("rst_instr32", 64'(ins32), 64'(0));
        chk("rst_tag32", 64'(tag32), 64'(0));
        chk("rst_valid64", 64'(val64), 64'(0));
        chk("rst_ready64", 64'(rdy64), 64'(1));
        chk("rst_imm64", imm64, 64'(0));
        chk("rst_tag64", 64'(tag64), 64'(0));
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        // Full table streamed back-to-back with out_ready=1
        out_ready = 1'b1;
        send(0);
        chk("latency1_valid32", 64'(val32), 64'(1));
        chk("latency1_valid64", 64'(val64), 64'(1));
        for (int i = 1; i < NV; i++) send(i);
        @(posedge clk);
        #1;
        chk("stream_all_out32", 64'(n_out32), 64'(NV));
        chk("stream_all_out64", 64'(n_out64), 64'(NV));
        chk("stream_idle_valid32", 64'(val32), 64'(0));

        // Backpressure: out_ready low for three edges while instructions arrive
        base32 = n_out32;
        out_ready = 1'b0;
        send(1);
        chk("bp_ready_after_1st", 64'(rdy32), 64'(1));
        send(2);
        chk("bp_ready_after_2nd", 64'(rdy32), 64'(0));
        chk("bp_ready64_after_2nd", 64'(rdy64), 64'(0));
        chk("bp_valid_stalled", 64'(val32), 64'(1));
        present(3);
        @(posedge clk);
        #1;
        chk("bp_ready_still_low", 64'(rdy32), 64'(0));
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_ready_rises", 64'(rdy32), 64'(1));
        send(3);
        send(4);
        drain();
        chk("bp_all_four_out", 64'(n_out32 - base32), 64'(4));

        // Random downstream stalls over the whole table
        done_flag = 1'b0;
        fork
            begin
                for (int i = 0; i < NV; i++) send(i);
                done_flag = 1'b1;
            end
            begin
                while (!done_flag) begin
                    out_ready = 1'($urandom_range(0, 1));
                    @(posedge clk);
                    #1;
                end
            end
        join
        drain();
        chk("rand_count_match", 64'(n_out32), 64'(n_out64));

        // Reset with two entries buffered
        out_ready = 1'b0;
        send(5);
        send(6);
        chk("pre_rst_ready_low", 64'(rdy32), 64'(0));
        rst = 1'b1;
        #1;
        chk("midrst_valid32", 64'(val32), 64'(0));
        chk("midrst_valid64", 64'(val64), 64'(0));
        chk("midrst_ready32", 64'(rdy32), 64'(1));
        chk("midrst_imm32", 64'(imm32), 64'(0));
        q32.delete();
        q64.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_no_stale32", 64'(val32), 64'(0));
            chk("post_rst_no_stale64", 64'(val64), 64'(0));
        end
        send(13);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
